// File: rtl/gene_pkg.sv
// Shared widths, result-kind encodings and sweep FSM encoding for the gene network
// sweep controller.
package gene_pkg;

   localparam int STATE_W = 8;
   localparam int CNT_W   = 9;

   localparam logic [1:0] KIND_FIX = 2'b00;
   localparam logic [1:0] KIND_CYC = 2'b01;
   localparam logic [1:0] KIND_TO  = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_ITER = 2'd2,
      ST_EMIT = 2'd3
   } sweep_state_e;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/gene_sweep_ctrl_brent.sv
// Brent cycle-detection datapath: tortoise/power/lambda registers plus a step
// budget timer, evaluated against the network output each iteration.
module gene_brent
   import gene_pkg::*;
#(
   parameter int STEP_W    = 10,
   parameter int MAX_STEPS = 1023
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               step,
   input  logic [STATE_W-1:0] x0,
   input  logic [STATE_W-1:0] net_f,
   output logic               hit,
   output logic               timeout,
   output logic [STEP_W-1:0]  len,
   output logic [STATE_W-1:0] attr
);

   localparam logic [STEP_W-1:0] STEPS_INIT = STEP_W'(MAX_STEPS);

   logic [STATE_W-1:0] tort_q, tort_d;
   logic [STEP_W:0]    power_q, power_d;
   logic [STEP_W-1:0]  lam_q, lam_d, lam_n;
   logic [STEP_W-1:0]  steps_left_q, steps_left_d;

   always_comb begin
      lam_n        = lam_q + 1'b1;
      hit          = (net_f == tort_q);
      // remaining budget of 1 means this is the last allowed iteration
      timeout      = (steps_left_q == STEP_W'(1));
      len          = lam_n;
      attr         = net_f;
      tort_d       = tort_q;
      power_d      = power_q;
      lam_d        = lam_q;
      steps_left_d = steps_left_q;
      if (load) begin
         tort_d       = x0;
         power_d      = (STEP_W+1)'(1);
         lam_d        = '0;
         steps_left_d = STEPS_INIT;
      end else if (step) begin
         steps_left_d = steps_left_q - 1'b1;
         if ({1'b0, lam_n} == power_q) begin
            tort_d  = net_f;
            power_d = power_q << 1;
            lam_d   = '0;
         end else begin
            lam_d = lam_n;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tort_q       <= '0;
         power_q      <= '0;
         lam_q        <= '0;
         steps_left_q <= '0;
      end else begin
         tort_q       <= tort_d;
         power_q      <= power_d;
         lam_q        <= lam_d;
         steps_left_q <= steps_left_d;
      end
   end

endmodule

// File: rtl/gene_sweep_ctrl.sv
// Sweeps every initial state in a programmed range through the gene network,
// classifies each trajectory and streams one result per state with running totals.
//
// state | meaning
// IDLE  | waiting for start; totals held from the last sweep
// LOAD  | seed x and the Brent datapath from the current initial state
// ITER  | one network step per cycle until detection or step budget exhausted
// EMIT  | result presented, held until res_ready; then next state or done
module gene_sweep_ctrl
   import gene_pkg::*;
#(
   parameter int STEP_W    = 10,
   parameter int MAX_STEPS = 1023
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [STATE_W-1:0] start_val,
   input  logic [STATE_W-1:0] end_val,
   output logic [STATE_W-1:0] net_x,
   input  logic [STATE_W-1:0] net_f,
   output logic               busy,
   output logic               done,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [STATE_W-1:0] res_init,
   output logic [1:0]         res_kind,
   output logic [STEP_W-1:0]  res_len,
   output logic [STATE_W-1:0] res_attr,
   output logic [CNT_W-1:0]   fp_count,
   output logic [CNT_W-1:0]   cyc_count,
   output logic [CNT_W-1:0]   to_count
);

   sweep_state_e       state_q, state_d;
   logic [STATE_W-1:0] cur_q, cur_d, last_q, last_d, x_q, x_d;
   logic [1:0]         res_kind_q, res_kind_d;
   logic [STEP_W-1:0]  res_len_q, res_len_d;
   logic [STATE_W-1:0] res_attr_q, res_attr_d;
   logic [CNT_W-1:0]   fp_q, fp_d, cyc_q, cyc_d, to_q, to_d;
   logic               done_q, done_d;

   logic               b_load, b_step, b_hit, b_timeout;
   logic [STEP_W-1:0]  b_len;
   logic [STATE_W-1:0] b_attr;

   assign b_load = (state_q == ST_LOAD);
   assign b_step = (state_q == ST_ITER) && !b_hit && !b_timeout;

   gene_brent #(
      .STEP_W    (STEP_W),
      .MAX_STEPS (MAX_STEPS)
   ) u_brent (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (b_load),
      .step    (b_step),
      .x0      (cur_q),
      .net_f   (net_f),
      .hit     (b_hit),
      .timeout (b_timeout),
      .len     (b_len),
      .attr    (b_attr)
   );

   always_comb begin
      state_d    = state_q;
      cur_d      = cur_q;
      last_d     = last_q;
      x_d        = x_q;
      res_kind_d = res_kind_q;
      res_len_d  = res_len_q;
      res_attr_d = res_attr_q;
      fp_d       = fp_q;
      cyc_d      = cyc_q;
      to_d       = to_q;
      done_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               cur_d   = start_val;
               last_d  = end_val;
               fp_d    = '0;
               cyc_d   = '0;
               to_d    = '0;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            x_d     = cur_q;
            state_d = ST_ITER;
         end
         ST_ITER: begin
            // a hit on the last budgeted step still counts as a detection
            if (b_hit) begin
               res_kind_d = (b_len == STEP_W'(1)) ? KIND_FIX : KIND_CYC;
               res_len_d  = b_len;
               res_attr_d = b_attr;
               state_d    = ST_EMIT;
            end else if (b_timeout) begin
               res_kind_d = KIND_TO;
               res_len_d  = '0;
               res_attr_d = '0;
               state_d    = ST_EMIT;
            end else begin
               x_d = net_f;
            end
         end
         ST_EMIT: begin
            if (res_ready) begin
               case (res_kind_q)
                  KIND_FIX: fp_d  = sat_inc(fp_q);
                  KIND_CYC: cyc_d = sat_inc(cyc_q);
                  KIND_TO:  to_d  = sat_inc(to_q);
                  default:  ;
               endcase
               if (cur_q == last_q) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  cur_d   = cur_q + 1'b1;
                  state_d = ST_LOAD;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cur_q      <= '0;
         last_q     <= '0;
         x_q        <= '0;
         res_kind_q <= '0;
         res_len_q  <= '0;
         res_attr_q <= '0;
         fp_q       <= '0;
         cyc_q      <= '0;
         to_q       <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_q      <= cur_d;
         last_q     <= last_d;
         x_q        <= x_d;
         res_kind_q <= res_kind_d;
         res_len_q  <= res_len_d;
         res_attr_q <= res_attr_d;
         fp_q       <= fp_d;
         cyc_q      <= cyc_d;
         to_q       <= to_d;
         done_q     <= done_d;
      end
   end

   assign net_x     = x_q;
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign res_valid = (state_q == ST_EMIT);
   assign res_init  = cur_q;
   assign res_kind  = res_kind_q;
   assign res_len   = res_len_q;
   assign res_attr  = res_attr_q;
   assign fp_count  = fp_q;
   assign cyc_count = cyc_q;
   assign to_count  = to_q;

endmodule
